// File: rtl/alu_seq.sv
// Registered ALU with stored carry for multi-word adds, an iterative shift-add
// multiplier and a start/busy/done handshake. Every output comes from a flop.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [3:0]           operation,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out,
    output logic [3:0]           flags
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic            carry_q, carry_d;
    logic            busy_d, done_d;
    logic [W2-1:0]   out_d;
    logic [3:0]      flags_d;

    // Single-cycle datapath evaluated on the live operands at the accept edge
    logic [W:0]      ext;
    logic [W-1:0]    alu_res;
    logic            alu_c, alu_v, alu_illegal;
    logic [3:0]      alu_flags;
    logic [W2-1:0]   alu_out;

    always_comb begin
        ext         = '0;
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_illegal = 1'b0;
        case (operation)
            OP_ADD: begin
                ext     = {1'b0, x} + {1'b0, y};
                alu_res = ext[W-1:0];
                alu_c   = ext[W];
                alu_v   = (x[W-1] == y[W-1]) && (alu_res[W-1] != x[W-1]);
            end
            OP_ADC: begin
                ext     = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, carry_q};
                alu_res = ext[W-1:0];
                alu_c   = ext[W];
                alu_v   = (x[W-1] == y[W-1]) && (alu_res[W-1] != x[W-1]);
            end
            OP_SUB: begin
                // Bit W of the zero-extended difference is the borrow
                ext     = {1'b0, x} - {1'b0, y};
                alu_res = ext[W-1:0];
                alu_c   = ext[W];
                alu_v   = (x[W-1] != y[W-1]) && (alu_res[W-1] != x[W-1]);
            end
            OP_NOT: alu_res = ~x;
            OP_AND: alu_res = x & y;
            OP_OR:  alu_res = x | y;
            OP_XOR: alu_res = x ^ y;
            OP_SHL: begin
                alu_res = {x[W-2:0], 1'b0};
                alu_c   = x[W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, x[W-1:1]};
                alu_c   = x[0];
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_out   = '0;
        alu_flags = 4'b0010;
        if (!alu_illegal) begin
            alu_out   = {{W{1'b0}}, alu_res};
            alu_flags = {alu_v, alu_res[W-1], (alu_res == '0), alu_c};
        end
    end

    // One shift-add step; on the last step this sum is the full product
    logic [W2-1:0]   prod;
    logic [3:0]      mul_flags;
    logic            last_step;

    always_comb begin
        prod      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_flags = {1'b0, prod[W2-1], (prod == '0), (prod[W2-1:W] != '0)};
        last_step = (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            carry_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            flags    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            carry_q  <= carry_d;
            busy     <= busy_d;
            done     <= done_d;
            out      <= out_d;
            flags    <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        carry_d  = carry_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        out_d    = out;
        flags_d  = flags;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (operation == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, x};
                        mplier_d = y;
                        busy_d   = 1'b1;
                    end else begin
                        out_d   = alu_out;
                        flags_d = alu_flags;
                        carry_d = alu_flags[0];
                        done_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                busy_d   = 1'b1;
                if (last_step) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = prod;
                    flags_d = mul_flags;
                    carry_d = mul_flags[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vector table, hand-built multi-cycle
// sequences, then random operations checked against an arithmetic model.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  operation;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    logic tb_carry = 1'b0;

    alu_seq #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x         (x),
        .y         (y),
        .operation (operation),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .flags     (flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Result {flags, out} from the opcode definitions using integer arithmetic
    function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        int ua, ub, sa, sb, r, sr;
        logic c, v, z, n;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 0;
        sr = 0;
        c  = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; sr = sa + sb; c = (r > 255); end
            4'd1: begin r = ua - ub; sr = sa - sb; c = (ua < ub); end
            4'd9: begin r = ua + ub + int'(cin); sr = sa + sb + int'(cin); c = (r > 255); end
            4'd2: r = 255 - ua;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: begin r = ua * 2; c = (ua >= 128); end
            4'd7: begin r = ua / 2; c = ((ua % 2) == 1); end
            4'd8: begin
                r = ua * ub;
                z = (r == 0);
                n = (r >= 32768);
                c = (r > 255);
                return {1'b0, n, z, c, 16'(r)};
            end
            default: return {4'b0010, 16'h0000};
        endcase
        r = r & 255;
        v = ((op == 4'd0) || (op == 4'd1) || (op == 4'd9)) && ((sr > 127) || (sr < -128));
        z = (r == 0);
        n = (r >= 128);
        return {v, n, z, c, 16'(r)};
    endfunction

    // Issue one op, then scramble inputs until done (bounded); lat counts cycles
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] o, output logic [3:0] f, output int lat);
        @(negedge clock);
        start = 1'b1;
        operation = op;
        x = a;
        y = b;
        lat = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            x = 8'($urandom);
            y = 8'($urandom);
            operation = 4'($urandom);
            lat++;
        end while (!done && lat < 40);
        o = out;
        f = flags;
    endtask

    vec_t vecs[13];
    logic [15:0] got_o;
    logic [3:0]  got_f;
    logic [19:0] exp_r;
    int lat, bc, dc, dlat;

    initial begin
        vecs[0]  = '{4'd0,  8'hFF, 8'h01, 16'h0000, 4'b0011};
        vecs[1]  = '{4'd1,  8'h80, 8'h01, 16'h007F, 4'b1000};
        vecs[2]  = '{4'd1,  8'h01, 8'h02, 16'h00FF, 4'b0101};
        vecs[3]  = '{4'd8,  8'hFF, 8'hFF, 16'hFE01, 4'b0101};
        vecs[4]  = '{4'd7,  8'h81, 8'h00, 16'h0040, 4'b0001};
        vecs[5]  = '{4'd6,  8'h81, 8'h00, 16'h0002, 4'b0001};
        vecs[6]  = '{4'd12, 8'h12, 8'h34, 16'h0000, 4'b0010};
        vecs[7]  = '{4'd3,  8'hF0, 8'h3C, 16'h0030, 4'b0000};
        vecs[8]  = '{4'd4,  8'h00, 8'h00, 16'h0000, 4'b0010};
        vecs[9]  = '{4'd5,  8'hAA, 8'h55, 16'h00FF, 4'b0100};
        vecs[10] = '{4'd2,  8'h00, 8'h00, 16'h00FF, 4'b0100};
        vecs[11] = '{4'd0,  8'h7F, 8'h01, 16'h0080, 4'b1100};
        vecs[12] = '{4'd8,  8'h00, 8'h05, 16'h0000, 4'b0010};

        reset = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        operation = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, got_o, got_f, lat);
            chk($sformatf("vec%0d_out", i), 32'(got_o), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_flags", i), 32'(got_f), 32'(vecs[i].exp_flags));
            chk($sformatf("vec%0d_lat", i), lat, (vecs[i].op == 4'd8) ? 9 : 1);
            @(negedge clock);
            chk($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(out), 32'(vecs[i].exp_out));
            tb_carry = vecs[i].exp_flags[0];
        end

        // MUL with an ADD start pulsed mid-multiply: busy 8 cycles, single done at 9
        @(negedge clock);
        start = 1'b1; operation = 4'd8; x = 8'hFF; y = 8'hFF;
        bc = 0; dc = 0; dlat = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock);
            if (busy) bc++;
            if (done) begin dc++; if (dlat == 0) dlat = i; end
            start = (i == 4);
            operation = 4'd0; x = 8'h03; y = 8'h04;
        end
        chk("mul_busy_cycles", bc, 8);
        chk("mul_done_latency", dlat, 9);
        chk("mul_done_count", dc, 1);
        chk("mul_out_held", 32'(out), 32'h0000FE01);
        chk("mul_flags", 32'(flags), 32'b0101);
        tb_carry = 1'b1;

        // ADD then ADC issued in the ADD's done cycle
        @(negedge clock);
        start = 1'b1; operation = 4'd0; x = 8'hFF; y = 8'h01;
        @(negedge clock);
        chk("chain_add_done", 32'(done), 32'd1);
        chk("chain_add_out", 32'(out), 32'h0);
        chk("chain_add_flags", 32'(flags), 32'b0011);
        start = 1'b1; operation = 4'd9; x = 8'h10; y = 8'h20;
        @(negedge clock);
        start = 1'b0;
        chk("chain_adc_done", 32'(done), 32'd1);
        chk("chain_adc_out", 32'(out), 32'h31);
        chk("chain_adc_flags", 32'(flags), 32'b0000);
        @(negedge clock);
        chk("chain_done_low", 32'(done), 32'd0);

        // Set stored carry, then reset in the 4th MUL cycle
        do_op(4'd0, 8'hFF, 8'h01, got_o, got_f, lat);
        chk("pre_reset_carry", 32'(got_f[0]), 32'd1);
        @(negedge clock);
        start = 1'b1; operation = 4'd8; x = 8'h0F; y = 8'h0F;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        dc = 0; bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) dc++;
            if (busy) bc++;
        end
        chk("abort_no_done", dc, 0);
        chk("abort_no_busy", bc, 0);
        do_op(4'd9, 8'h01, 8'h01, got_o, got_f, lat);
        chk("post_reset_adc_carry_cleared", 32'(got_o), 32'h2);
        do_op(4'd0, 8'h03, 8'h04, got_o, got_f, lat);
        chk("post_reset_add", 32'(got_o), 32'h7);
        tb_carry = 1'b0;

        // Random operations against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 5 == 0) a = 8'(($urandom % 2 == 0) ? 8'hFF : 8'h80);
            exp_r = model(op, a, b, tb_carry);
            do_op(op, a, b, got_o, got_f, lat);
            chk($sformatf("rnd%0d_op%0d_out", i, op), 32'(got_o), 32'(exp_r[15:0]));
            chk($sformatf("rnd%0d_op%0d_flags", i, op), 32'(got_f), 32'(exp_r[19:16]));
            chk($sformatf("rnd%0d_op%0d_lat", i, op), lat, (op == 4'd8) ? 9 : 1);
            tb_carry = exp_r[16];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU. Adds an iterative multiplier, a stored carry for multi-word arithmetic, and a start/busy/done handshake.
- Sits between the register file and the writeback mux of the datapath.
- All outputs are registered.
- Single-cycle ops finish in 1 cycle. MUL takes WIDTH+1 cycles.

Parameters:
- WIDTH, 8: operand width in bits (legal range 4..32).

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- operation  in  4  opcode
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse; out/flags are valid from this cycle onwards
- out  out  2*WIDTH  result
- flags  out  4  bit0 carry, bit1 zero, bit2 neg, bit3 overflow

Behaviour:
- Interface: one clock. Reset is synchronous and active-high. Ports are named clock and reset.
- Reset: busy=0, done=0, out=0, flags=0, FSM=IDLE, stored carry=0. Reset during MUL aborts the operation with no done pulse.
- Opcodes:
  - 0 ADD
  - 1 SUB (x-y)
  - 2 NOT (~x)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL (x<<1)
  - 7 SHR (x>>1, logical)
  - 8 MUL (unsigned)
  - 9 ADC (x+y+stored carry)
  - 10-15 illegal
- Accept: start=1 with busy=0 at an edge. Operands and opcode are latched at that edge; later changes have no effect.
- Single-cycle ops: out, flags and done=1 are valid in the cycle after the accept edge. done returns to 0 the following cycle unless another op completes.
- MUL FSM (IDLE -> MUL -> IDLE):
  - Accept edge enters MUL with counter=0.
  - busy=1 for exactly WIDTH cycles; one shift-add step per edge.
  - The edge that performs step WIDTH returns to IDLE and loads out/flags; done=1 and busy=0 in the next cycle.
  - Total: done is high WIDTH+1 cycles after the start cycle.
- start while busy=1: ignored, no queuing.
- start in the done cycle: accepted (back-to-back issue allowed).
- out/flags hold their value between done pulses.
- Width rules: non-MUL results occupy out[WIDTH-1:0]; out[2W-1:W]=0. MUL fills all 2*WIDTH bits.
- Carry flag:
  - ADD/ADC: carry out of bit W-1.
  - SUB: borrow, i.e. 1 iff x<y unsigned.
  - SHL: x[W-1]. SHR: x[0].
  - MUL: 1 iff the upper half is nonzero.
  - Logic ops: 0.
- Zero flag: result bits==0 (low half for non-MUL, full 2W for MUL).
- Neg flag: MSB of the result (bit W-1, or bit 2W-1 for MUL).
- Overflow flag: signed two's-complement overflow for ADD/ADC/SUB; 0 otherwise.
- Stored carry: updated to flags[0] on every completion, including illegal ops. ADC uses the value held at its accept edge.
- Illegal opcode: completes like a single-cycle op with out=0 and flags=4'b0010.
- Wrap-around: all arithmetic is modulo 2^W. Result bit W (or 2W) is used only for carry.

Test Plan (WIDTH=8):
- ADD x=0xFF y=0x01 -> out=0x0000, flags C=1 Z=1 N=0 V=0. done exactly 1 cycle after start, 1 cycle wide.
- SUB x=0x80 y=0x01 -> out=0x007F, C=0 Z=0 N=0 V=1. SUB x=0x01 y=0x02 -> out=0x00FF, C=1 N=1.
- MUL x=0xFF y=0xFF -> out=0xFE01, C=1 N=1. busy high 8 cycles, done 9 cycles after start. A start (ADD) pulsed mid-multiply is ignored and out stays 0xFE01.
- Chain ADD 0xFF+0x01 (C=1), then ADC 0x10+0x20 -> out=0x0031, C=0. Issue the ADC in the done cycle of the ADD (back-to-back).
- SHR x=0x81 -> out=0x0040, C=1. SHL x=0x81 -> out=0x0002, C=1. opcode 12 -> out=0, flags=4'b0010.
- Assert reset in the 4th MUL cycle -> next cycle busy=0, done=0, out=0, flags=0, and no done pulse follows. A subsequent ADD 3+4 gives out=0x0007.
